// File: rtl/ospfb_stream_ctrl_if.sv
// AXI-Stream style sample channel ({im, re} payload) between the FIFO, sequencer and OSPFB.
interface ospfb_stream_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ospfb_stream_ctrl.sv
// Prefill/run/halt sequencer feeding the OSPFB with tlast every DEC_FAC samples.
// Zero-latency pass-through in RUN; m-side backpressure drives s_axis tready directly, blocked elsewhere.
module ospfb_stream_ctrl #(
  parameter int WIDTH            = 16,
  parameter int DEC_FAC          = 48,
  parameter int FIFO_DEPTH       = 16,
  parameter int DATA_COUNT_WIDTH = $clog2(FIFO_DEPTH),
  parameter int PREFILL_LVL      = FIFO_DEPTH / 2,
  parameter bit HALT_ON_UNDERRUN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic                        clr,
  input  logic [DATA_COUNT_WIDTH-1:0] rd_count,
  ospfb_stream_ctrl_if.slave          s_axis,
  ospfb_stream_ctrl_if.master         m_axis,
  output logic                        ospfb_en,
  output logic [1:0]                  state,
  output logic                        underrun,
  output logic [15:0]                 underrun_cnt,
  output logic [31:0]                 frame_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PREFILL = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  localparam int PW = (DEC_FAC > 1) ? $clog2(DEC_FAC) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DEC_FAC - 1);
  // One extra bit so a level equal to FIFO_DEPTH stays representable.
  localparam logic [DATA_COUNT_WIDTH:0] LVL = (DATA_COUNT_WIDTH + 1)'(PREFILL_LVL);

  logic [1:0]    next_state;
  logic [PW-1:0] phase;
  logic          run;
  logic          hs;
  logic          at_last;
  logic          ur_ev;

  assign run     = (state == S_RUN);
  assign hs      = run && s_axis.tvalid && m_axis.tready;
  assign at_last = (phase == PHASE_LAST);
  assign ur_ev   = run && m_axis.tready && !s_axis.tvalid;

  assign m_axis.tdata  = run ? s_axis.tdata : '0;
  assign m_axis.tvalid = run && s_axis.tvalid;
  assign m_axis.tlast  = run && at_last;
  assign s_axis.tready = run && m_axis.tready;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (en) next_state = S_PREFILL;
      end
      S_PREFILL: begin
        if (!en)                             next_state = S_IDLE;
        else if ({1'b0, rd_count} >= LVL)    next_state = S_RUN;
      end
      S_RUN: begin
        // A disabled run only exits on a hop boundary so the OSPFB never sees a partial hop.
        if (ur_ev && HALT_ON_UNDERRUN)
          next_state = S_HALT;
        else if (!en && ((hs && at_last) || (phase == '0 && !hs)))
          next_state = S_IDLE;
      end
      default: begin
        if (!en) next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      phase        <= '0;
      ospfb_en     <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      state    <= next_state;
      ospfb_en <= (next_state == S_RUN);

      if (next_state != S_RUN)
        phase <= '0;
      else if (hs)
        phase <= at_last ? '0 : phase + 1'b1;

      if (clr) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
        frame_cnt    <= '0;
      end else begin
        if (ur_ev) begin
          underrun <= 1'b1;
          if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end
        if (hs && at_last) frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ospfb_stream_ctrl.sv
// Directed-plus-random bench for ospfb_stream_ctrl; two instances differ only in underrun policy.
module tb_ospfb_stream_ctrl;
  localparam int WIDTH = 16;
  localparam int DEC   = 48;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        clr;
  logic [3:0]  rd_count;
  logic [31:0] s_dat;
  logic        s_vld;
  logic        m_rdy;

  logic        ospfb_en_h, ospfb_en_c, underrun_h, underrun_c;
  logic [1:0]  state_h, state_c;
  logic [15:0] ucnt_h, ucnt_c;
  logic [31:0] frame_h, frame_c;

  int vectors = 0;
  int miscompares = 0;
  logic exp_run = 1'b0;
  int nx = 0;
  int frames = 0;

  always #5 clk = ~clk;

  ospfb_stream_ctrl_if #(.WIDTH(WIDTH)) s_h ();
  ospfb_stream_ctrl_if #(.WIDTH(WIDTH)) m_h ();
  ospfb_stream_ctrl_if #(.WIDTH(WIDTH)) s_c ();
  ospfb_stream_ctrl_if #(.WIDTH(WIDTH)) m_c ();

  assign s_h.tdata = s_dat;  assign s_h.tvalid = s_vld;  assign s_h.tlast = 1'b0;
  assign s_c.tdata = s_dat;  assign s_c.tvalid = s_vld;  assign s_c.tlast = 1'b0;
  assign m_h.tready = m_rdy;
  assign m_c.tready = m_rdy;

  ospfb_stream_ctrl #(.WIDTH(WIDTH), .DEC_FAC(DEC), .FIFO_DEPTH(16), .PREFILL_LVL(8),
                      .HALT_ON_UNDERRUN(1'b1)) dut_h (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .rd_count(rd_count),
    .s_axis(s_h), .m_axis(m_h), .ospfb_en(ospfb_en_h), .state(state_h),
    .underrun(underrun_h), .underrun_cnt(ucnt_h), .frame_cnt(frame_h));

  ospfb_stream_ctrl #(.WIDTH(WIDTH), .DEC_FAC(DEC), .FIFO_DEPTH(16), .PREFILL_LVL(8),
                      .HALT_ON_UNDERRUN(1'b0)) dut_c (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .rd_count(rd_count),
    .s_axis(s_c), .m_axis(m_c), .ospfb_en(ospfb_en_c), .state(state_c),
    .underrun(underrun_c), .underrun_cnt(ucnt_c), .frame_cnt(frame_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of streaming on the halting instance; the model only knows hop length and run flag.
  task automatic cyc(input logic v, input logic r, output logic hs, output logic last);
    logic [31:0] d;
    d = $urandom;
    s_vld = v; m_rdy = r; s_dat = d;
    @(negedge clk);
    chk("m_tvalid", {31'd0, m_h.tvalid}, {31'd0, exp_run && v});
    chk("s_tready", {31'd0, s_h.tready}, {31'd0, exp_run && r});
    chk("m_tlast",  {31'd0, m_h.tlast},  {31'd0, exp_run && (nx % DEC == DEC - 1)});
    if (exp_run && v) chk("m_tdata", m_h.tdata, d);
    hs   = exp_run && v && r;
    last = hs && (nx % DEC == DEC - 1);
    if (hs) nx++;
    if (last) frames++;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},    {30'd0, state_h},    32'd0);
    chk({tag, "_ospfb_en"}, {31'd0, ospfb_en_h}, 32'd0);
    chk({tag, "_underrun"}, {31'd0, underrun_h}, 32'd0);
    chk({tag, "_ucnt"},     {16'd0, ucnt_h},     32'd0);
    chk({tag, "_frame"},    frame_h,             32'd0);
    chk({tag, "_tvalid"},   {31'd0, m_h.tvalid}, 32'd0);
    chk({tag, "_tready"},   {31'd0, s_h.tready}, 32'd0);
    chk({tag, "_tlast"},    {31'd0, m_h.tlast},  32'd0);
    chk({tag, "_state_c"},  {30'd0, state_c},    32'd0);
  endtask

  initial begin
    logic hs, last;
    int more;
    rstn = 1'b0; en = 1'b0; clr = 1'b0; rd_count = 4'd0;
    s_vld = 1'b0; m_rdy = 1'b0; s_dat = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // Prefill: FIFO fills one word per cycle; RUN one cycle after level 8 is seen.
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold", {30'd0, state_h}, 32'd0);
    en = 1'b1; s_vld = 1'b1; m_rdy = 1'b1;
    @(posedge clk); #1;
    chk("enter_prefill", {30'd0, state_h}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      rd_count = 4'(k);
      @(negedge clk);
      chk("prefill_state", {30'd0, state_h}, 32'd1);
      chk("prefill_no_pop", {31'd0, s_h.tready}, 32'd0);
      chk("prefill_no_vld", {31'd0, m_h.tvalid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("run_state", {30'd0, state_h}, 32'd2);
    chk("run_ospfb_en", {31'd0, ospfb_en_h}, 32'd1);
    exp_run = 1'b1; nx = 0; frames = 0;

    // Framing: 480 continuous samples -> 10 hops.
    for (int i = 0; i < 480; i++) cyc(1'b1, 1'b1, hs, last);
    chk("frame_cnt_480", frame_h, 32'd10);
    chk("frame_cnt_480_c", frame_c, 32'd10);

    // Random backpressure without gaps while ready is high.
    for (int i = 0; i < 150; i++) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      cyc(1'b1, r, hs, last);
    end
    for (int i = 0; i < 150; i++) begin
      logic r, v;
      r = 1'($urandom_range(0, 1));
      v = r ? 1'b1 : 1'($urandom_range(0, 1));
      cyc(v, r, hs, last);
    end
    chk("frame_cnt_rand", frame_h, 32'(frames));

    // Graceful stop: en drops at phase 20, 27 further transfers close the hop.
    for (int i = 0; i < 2 * DEC && (nx % DEC) != 20; i++) cyc(1'b1, 1'b1, hs, last);
    en = 1'b0;
    cyc(1'b1, 1'b1, hs, last);
    more = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, hs, last);
      if (hs) more++;
      if (last) break;
      chk("drain_state", {30'd0, state_h}, 32'd2);
    end
    exp_run = 1'b0;
    chk("drain_count", 32'(more), 32'd27);
    chk("stop_state", {30'd0, state_h}, 32'd0);
    chk("stop_ospfb_en", {31'd0, ospfb_en_h}, 32'd0);
    chk("stop_frames", frame_h, 32'(frames));

    // Restart with FIFO already at level, then underrun gaps.
    en = 1'b1; rd_count = 4'd8; s_vld = 1'b0; m_rdy = 1'b0;
    @(posedge clk); #1;
    chk("restart_prefill", {30'd0, state_h}, 32'd1);
    @(posedge clk); #1;
    chk("restart_run", {30'd0, state_h}, 32'd2);
    s_vld = 1'b0; m_rdy = 1'b1;
    @(posedge clk); #1;
    chk("ur_halt_state", {30'd0, state_h}, 32'd3);
    chk("ur_halt_flag", {31'd0, underrun_h}, 32'd1);
    chk("ur_halt_cnt", {16'd0, ucnt_h}, 32'd1);
    chk("ur_halt_ospfb_en", {31'd0, ospfb_en_h}, 32'd0);
    chk("ur_halt_blocked", {31'd0, s_h.tready}, 32'd0);
    chk("ur_cnt_state", {30'd0, state_c}, 32'd2);
    repeat (4) @(posedge clk);
    #1;
    chk("ur_cnt_5", {16'd0, ucnt_c}, 32'd5);
    chk("ur_cnt_flag", {31'd0, underrun_c}, 32'd1);
    chk("ur_cnt_still_run", {30'd0, state_c}, 32'd2);
    chk("ur_halt_cnt_held", {16'd0, ucnt_h}, 32'd1);
    chk("ur_halt_held", {30'd0, state_h}, 32'd3);
    en = 1'b0; m_rdy = 1'b0;
    @(posedge clk); #1;
    chk("halt_exit", {30'd0, state_h}, 32'd0);
    chk("cnt_exit", {30'd0, state_c}, 32'd0);
    chk("cnt_frames", frame_c, 32'(frames));
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_ucnt_c", {16'd0, ucnt_c}, 32'd0);
    chk("clr_flag_c", {31'd0, underrun_c}, 32'd0);
    chk("clr_ucnt_h", {16'd0, ucnt_h}, 32'd0);
    chk("clr_frame", frame_h, 32'd0);

    // Async reset mid-hop at phase 30 of the second hop.
    en = 1'b1; rd_count = 4'd8;
    repeat (2) @(posedge clk);
    #1;
    chk("rerun_state", {30'd0, state_h}, 32'd2);
    exp_run = 1'b1; nx = 0; frames = 0;
    for (int i = 0; i < DEC + 30; i++) cyc(1'b1, 1'b1, hs, last);
    chk("pre_reset_frame", frame_h, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ospfb_stream_ctrl.md
# ospfb_stream_ctrl

Run-control sequencer between the read side of the clock-crossing sample FIFO and the OSPFB input stream, in the OSPFB clock domain. It prefills the FIFO to a programmed level before starting the filterbank, gates the AXI-Stream handshake by state, and marks decimation-phase boundaries with `tlast` every `DEC_FAC` samples. It also detects input underruns, and stops only on a frame boundary when disabled, so the OSPFB never sees a partial hop.

## Interface
Parameters:
- `WIDTH`, 16, real/imag component width; stream tdata is `2*WIDTH` bits ({im, re}).
- `DEC_FAC`, 48, samples per OSPFB hop; sets the tlast period.
- `FIFO_DEPTH`, 16, depth of the upstream FIFO.
- `DATA_COUNT_WIDTH`, `$clog2(FIFO_DEPTH)`, width of `rd_count`.
- `PREFILL_LVL`, `FIFO_DEPTH/2`, FIFO occupancy required to leave PREFILL.
- `HALT_ON_UNDERRUN`, 1: 1 = underrun halts; 0 = count only.

Ports:
- `clk`  in  1  OSPFB-domain clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset; release is synchronous to `clk`.
- `en`  in  1  run request.
- `clr`  in  1  one-cycle pulse; clears `underrun`, `underrun_cnt`, `frame_cnt`.
- `rd_count`  in  `DATA_COUNT_WIDTH`  FIFO read-side occupancy.
- `s_axis_tdata`  in  `2*WIDTH`  samples from the FIFO.
- `s_axis_tvalid`  in  1  FIFO has data.
- `s_axis_tready`  out  1  pop to the FIFO.
- `m_axis_tdata`  out  `2*WIDTH`  samples to the OSPFB.
- `m_axis_tvalid`  out  1  sample valid toward the OSPFB.
- `m_axis_tlast`  out  1  last sample of a hop.
- `m_axis_tready`  in  1  OSPFB accepts a sample.
- `ospfb_en`  out  1  registered enable to the OSPFB.
- `state`  out  2  IDLE=0, PREFILL=1, RUN=2, HALT=3.
- `underrun`  out  1  sticky underrun flag.
- `underrun_cnt`  out  16  underrun cycles, saturating at 16'hFFFF.
- `frame_cnt`  out  32  completed hops, wraps modulo 2^32.

## Operation
- IDLE: `s_axis_tready`=0, `m_axis_tvalid`=0, `ospfb_en`=0. `en`=1 moves to PREFILL.
- PREFILL: handshake stays blocked. If `en`=0, return to IDLE. If `rd_count >= PREFILL_LVL`, move to RUN, with the sample counter `phase` set to 0.
- RUN datapath is combinational pass-through: `m_axis_tdata`=`s_axis_tdata`, `m_axis_tvalid`=`s_axis_tvalid`, `s_axis_tready`=`m_axis_tready`.
- `phase` (`$clog2(DEC_FAC)` bits) increments on each m-side handshake and wraps from `DEC_FAC-1` to 0.
- `m_axis_tlast` = (state==RUN) && (`phase`==`DEC_FAC-1`).
- A handshake while tlast is high increments `frame_cnt`.
- Underrun: in RUN with `m_axis_tready`=1 and `s_axis_tvalid`=0.
  - Each such cycle sets `underrun` and increments `underrun_cnt` (saturating).
  - If `HALT_ON_UNDERRUN`=1, move to HALT in the next cycle.
- `en`=0 in RUN: keep streaming until the tlast handshake, then go to IDLE in the next cycle. If `phase`==0 and no handshake occurs that cycle, go to IDLE directly.
- HALT: handshake blocked, `ospfb_en`=0. Leave to IDLE only when `en`=0. `phase` is reset to 0 on entry.
- `clr` has priority over a same-cycle increment: the counters and flag become 0.
- Underrun takes priority over an `en`-drop exit in the same cycle.

## Timing
- Reset values (`rstn`=0): `state`=IDLE, `phase`=0, `ospfb_en`=0, `underrun`=0, `underrun_cnt`=0, `frame_cnt`=0. Combinational outputs are 0 because state is IDLE.
- `rstn` asserted mid-frame returns to IDLE immediately, with no drain.
- `state` is registered and updates one cycle after its condition is sampled.
- `ospfb_en` = registered (next_state==RUN), so it rises in the same cycle that `state` shows RUN.
- Data latency is 0 cycles through the block; no buffering. Gating is a pure function of `state`.
- With `PREFILL_LVL`=0, PREFILL lasts exactly one cycle.
- `rd_count` is used directly, with no synchronisation; it is already in the `clk` domain.

## Test plan
- Prefill: `PREFILL_LVL`=8, `en`=1, fill the FIFO one word per cycle. Required: state goes 0→1; RUN (2) appears exactly one cycle after `rd_count` reaches 8; no handshake occurs before RUN.
- Framing: `DEC_FAC`=48, 480 samples with continuous valid/ready. Required: tlast on samples 47, 95, …, 479; `frame_cnt`=10; data bit-exact.
- Graceful stop: drop `en` at `phase`=20. Required: 27 more transfers ending with tlast, then IDLE; `ospfb_en` falls in the same cycle that `state` returns to IDLE.
- Underrun halt: `HALT_ON_UNDERRUN`=1, drop tvalid for one cycle while ready is high. Required: `underrun`=1, `underrun_cnt`=1, HALT the next cycle; returns to IDLE after `en`=0.
- Underrun count: `HALT_ON_UNDERRUN`=0, 5 gap cycles. Required: stays in RUN, `underrun_cnt`=5; `clr` pulse returns the count and flag to 0.
- Async reset mid-RUN: assert `rstn`=0 at `phase`=30. Required: all outputs are at their reset values before the next clock edge.
